// File: rtl/reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_pkg
// Description : Shared types and default sizing for the multi-port register
//               bank and its clear-sweep controller.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_bank_pkg;

    // Bank operating state: sweeping zeros into the array, or serving traffic
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_NRD   = 4;
    localparam int DEF_NWR   = 2;

endpackage
`default_nettype wire

// File: rtl/reg_bank_clear_fsm.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_clear_fsm
// Description : Clear-sweep sequencer. Walks a counter over every register
//               index while in CLEAR, then settles in READY until a soft
//               clear request or reset restarts the sweep from index 0.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_clear_fsm
    import reg_bank_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          busy,
    output logic [AW-1:0] cnt
);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    // Next state: sweep advances one index per cycle; clr_req only acts in READY
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            if (cnt_q == AW'(DEPTH - 1)) begin
                state_d = ST_READY;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (clr_req) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
        end
        busy_d = (state_d == ST_CLEAR);
    end

    // State registers; reset parks the sequencer at the start of a sweep
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign cnt  = cnt_q;

endmodule
`default_nettype wire

// File: rtl/reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank
// Description : Multi-port register bank with combinational reads, optional
//               write-to-read bypass, per-port zero forcing, a constant
//               operand on read port 0, write collision flagging and a
//               hardware clear sweep after reset or on request.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    parameter  int NRD   = DEF_NRD,
    parameter  int NWR   = DEF_NWR,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRD*AW-1:0]    rd_addr,
    input  logic [NRD-1:0]       rd_zero,
    input  logic                 const_sel,
    input  logic [WIDTH-1:0]     const_val,
    output logic [NRD*WIDTH-1:0] rd_data,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*AW-1:0]    wr_addr,
    input  logic [NWR*WIDTH-1:0] wr_data,
    input  logic                 fwd_en,
    input  logic                 clr_req,
    output logic                 busy,
    output logic                 wr_conflict
);

    logic [AW-1:0]    sweep_cnt;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wa [NWR];
    logic [WIDTH-1:0] wd [NWR];
    logic [AW-1:0]    ra [NRD];
    logic             conflict_q, conflict_d;

    reg_bank_clear_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_fsm (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_req (clr_req),
        .busy    (busy),
        .cnt     (sweep_cnt)
    );

    generate
        for (genvar j = 0; j < NWR; j++) begin : g_wr_unpack
            assign wa[j] = wr_addr[j*AW +: AW];
            assign wd[j] = wr_data[j*WIDTH +: WIDTH];
        end
        for (genvar i = 0; i < NRD; i++) begin : g_rd_unpack
            assign ra[i] = rd_addr[i*AW +: AW];
        end
    endgenerate

    // Array update: sweep zeroes one entry per cycle, otherwise ascending port
    // order lets the highest-index writer win a collision
    always_comb begin
        mem_d = mem_q;
        if (busy) begin
            mem_d[sweep_cnt] = '0;
        end else if (!clr_req) begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j]) begin
                    mem_d[wa[j]] = wd[j];
                end
            end
        end
    end

    // Array storage; held during reset since the following sweep clears it
    always_ff @(posedge clk) begin
        if (rst_n) begin
            mem_q <= mem_d;
        end
    end

    // Collision detect: any two enabled write ports aimed at one address
    always_comb begin
        conflict_d = 1'b0;
        if (!busy && !clr_req) begin
            for (int j = 0; j < NWR; j++) begin
                for (int k = j + 1; k < NWR; k++) begin
                    if (wr_en[j] && wr_en[k] && (wa[j] == wa[k])) begin
                        conflict_d = 1'b1;
                    end
                end
            end
        end
    end

    // Collision flag register, visible for the single following cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign wr_conflict = conflict_q;

    generate
        for (genvar i = 0; i < NRD; i++) begin : g_rd
            logic             byp_hit;
            logic [WIDTH-1:0] byp_data;
            logic [WIDTH-1:0] rd_val;

            // Bypass search: the last matching port in ascending order wins
            always_comb begin
                byp_hit  = 1'b0;
                byp_data = '0;
                if (fwd_en && !busy) begin
                    for (int j = 0; j < NWR; j++) begin
                        if (wr_en[j] && (wa[j] == ra[i])) begin
                            byp_hit  = 1'b1;
                            byp_data = wd[j];
                        end
                    end
                end
            end

            // Read source priority: zero, constant (port 0), busy, bypass, array
            always_comb begin
                if (rd_zero[i]) begin
                    rd_val = '0;
                end else if ((i == 0) && const_sel) begin
                    rd_val = const_val;
                end else if (busy) begin
                    rd_val = '0;
                end else if (byp_hit) begin
                    rd_val = byp_data;
                end else begin
                    rd_val = mem_q[ra[i]];
                end
            end

            assign rd_data[i*WIDTH +: WIDTH] = rd_val;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bank
// Description : Self-checking bench for reg_bank: directed vector table plus
//               hand-written reset, clear-sweep and restart sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bank;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int NRD   = 4;
    localparam int NWR   = 2;
    localparam int AW    = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD-1:0]       rd_zero;
    logic                 const_sel;
    logic [WIDTH-1:0]     const_val;
    logic [NRD*WIDTH-1:0] rd_data;
    logic [NWR-1:0]       wr_en;
    logic [NWR*AW-1:0]    wr_addr;
    logic [NWR*WIDTH-1:0] wr_data;
    logic                 fwd_en;
    logic                 clr_req;
    logic                 busy;
    logic                 wr_conflict;

    int n_cmp = 0;
    int n_bad = 0;

    reg_bank #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .NRD   (NRD),
        .NWR   (NWR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr     (rd_addr),
        .rd_zero     (rd_zero),
        .const_sel   (const_sel),
        .const_val   (const_val),
        .rd_data     (rd_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .fwd_en      (fwd_en),
        .clr_req     (clr_req),
        .busy        (busy),
        .wr_conflict (wr_conflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]        we;
        logic [3:0]        wa0;
        logic [31:0]       wd0;
        logic [3:0]        wa1;
        logic [31:0]       wd1;
        logic              fwd;
        logic [3:0][3:0]   ra;
        logic [3:0]        rz;
        logic              cs;
        logic [31:0]       cv;
        logic [3:0][31:0]  exp_rd;
        logic              exp_cf;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(
        input logic [1:0] we, input logic [3:0] wa0, input logic [31:0] wd0,
        input logic [3:0] wa1, input logic [31:0] wd1, input logic fwd,
        input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] r3,
        input logic [3:0] rz, input logic cs, input logic [31:0] cv,
        input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3,
        input logic cf);
        vec_t v;
        v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1; v.fwd = fwd;
        v.ra[0] = r0; v.ra[1] = r1; v.ra[2] = r2; v.ra[3] = r3;
        v.rz = rz; v.cs = cs; v.cv = cv;
        v.exp_rd[0] = e0; v.exp_rd[1] = e1; v.exp_rd[2] = e2; v.exp_rd[3] = e3;
        v.exp_cf = cf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        wr_en     = '0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr   = '0;
        rd_zero   = '0;
        const_sel = 1'b0;
        const_val = '0;
        fwd_en    = 1'b0;
        clr_req   = 1'b0;
    endtask

    task automatic rd_chk(input logic [3:0] a, input logic [31:0] e, input string nm);
        idle();
        rd_addr = {4{a}};
        #1;
        chk(nm, rd_data[31:0], e);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        logic [3:0][3:0] ra;

        // Directed vectors, starting from an all-zero array in READY
        vecs[0]  = mk(2'b01, 4'd3, 32'hDEADBEEF, 4'd0, 32'h0, 1'b1, 4'd0, 4'd3, 4'd3, 4'd1, 4'b0000, 1'b0, 32'h0,
                      32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 1'b0);
        vecs[1]  = mk(2'b01, 4'd6, 32'hCAFEF00D, 4'd0, 32'h0, 1'b0, 4'd6, 4'd3, 4'd6, 4'd0, 4'b0000, 1'b0, 32'h0,
                      32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0);
        vecs[2]  = mk(2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b0, 4'd6, 4'd3, 4'd0, 4'd0, 4'b0000, 1'b0, 32'h0,
                      32'hCAFEF00D, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0);
        vecs[3]  = mk(2'b11, 4'd5, 32'h11, 4'd5, 32'h22, 1'b1, 4'd5, 4'd5, 4'd6, 4'd3, 4'b0000, 1'b0, 32'h0,
                      32'h22, 32'h22, 32'hCAFEF00D, 32'hDEADBEEF, 1'b1);
        vecs[4]  = mk(2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b0, 4'd5, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b0, 32'h0,
                      32'h22, 32'h0, 32'h0, 32'h0, 1'b0);
        vecs[5]  = mk(2'b11, 4'd7, 32'hAAAA0001, 4'd8, 32'hBBBB0002, 1'b1, 4'd7, 4'd8, 4'd7, 4'd8, 4'b1010, 1'b0, 32'h0,
                      32'hAAAA0001, 32'h0, 32'hAAAA0001, 32'h0, 1'b0);
        vecs[6]  = mk(2'b10, 4'd7, 32'hFFFFFFFF, 4'd7, 32'h12345678, 1'b0, 4'd7, 4'd8, 4'd9, 4'd6, 4'b0000, 1'b0, 32'h0,
                      32'hAAAA0001, 32'hBBBB0002, 32'h0, 32'hCAFEF00D, 1'b0);
        vecs[7]  = mk(2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b0, 4'd7, 4'd7, 4'd5, 4'd3, 4'b0000, 1'b1, 32'hA5A5A5A5,
                      32'hA5A5A5A5, 32'h12345678, 32'h22, 32'hDEADBEEF, 1'b0);
        vecs[8]  = mk(2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b0, 4'd7, 4'd5, 4'd8, 4'd6, 4'b0001, 1'b1, 32'hA5A5A5A5,
                      32'h0, 32'h22, 32'hBBBB0002, 32'hCAFEF00D, 1'b0);
        vecs[9]  = mk(2'b11, 4'd9, 32'h1, 4'd9, 32'h2, 1'b0, 4'd9, 4'd9, 4'd9, 4'd9, 4'b0000, 1'b0, 32'h0,
                      32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        vecs[10] = mk(2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b1, 4'd9, 4'd9, 4'd9, 4'd9, 4'b0000, 1'b0, 32'h0,
                      32'h2, 32'h2, 32'h2, 32'h2, 1'b0);
        vecs[11] = mk(2'b11, 4'd10, 32'h10, 4'd11, 32'h11, 1'b1, 4'd11, 4'd10, 4'd12, 4'd10, 4'b0000, 1'b0, 32'h0,
                      32'h11, 32'h10, 32'h0, 32'h10, 1'b0);

        // Reset for one edge, then exercise the constant path while busy
        idle();
        rst_n = 1'b0;
        tick();
        chk("reset_busy", 32'(busy), 32'h1);
        chk("reset_conflict", 32'(wr_conflict), 32'h0);
        const_sel = 1'b1;
        const_val = 32'hA5A5A5A5;
        rd_zero   = 4'b0001;
        rd_addr   = {4'd3, 4'd2, 4'd1, 4'd0};
        #1;
        chk("busy_const_zeroed", rd_data[31:0], 32'h0);
        rd_zero = 4'b0000;
        #1;
        chk("busy_const_val", rd_data[31:0], 32'hA5A5A5A5);
        chk("busy_port1_zero", rd_data[63:32], 32'h0);
        idle();

        // Release and measure the sweep length
        rst_n = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk("reset_sweep_len", 32'(n), 32'd16);

        // Every register reads zero after the sweep
        for (int g = 0; g < 4; g++) begin
            for (int i = 0; i < 4; i++) ra[i] = 4'(4 * g + i);
            rd_addr = ra;
            #1;
            for (int i = 0; i < 4; i++) chk($sformatf("init_reg%0d", 4 * g + i), rd_data[i*32 +: 32], 32'h0);
        end

        // Table-driven vectors
        for (int v = 0; v < 12; v++) begin
            wr_en     = vecs[v].we;
            wr_addr   = {vecs[v].wa1, vecs[v].wa0};
            wr_data   = {vecs[v].wd1, vecs[v].wd0};
            fwd_en    = vecs[v].fwd;
            rd_addr   = vecs[v].ra;
            rd_zero   = vecs[v].rz;
            const_sel = vecs[v].cs;
            const_val = vecs[v].cv;
            clr_req   = 1'b0;
            #1;
            for (int i = 0; i < 4; i++) chk($sformatf("vec%0d_rd%0d", v, i), rd_data[i*32 +: 32], vecs[v].exp_rd[i]);
            tick();
            chk($sformatf("vec%0d_conflict", v), 32'(wr_conflict), 32'(vecs[v].exp_cf));
        end
        idle();
        tick();

        // Soft clear with concurrent colliding writes that must be dropped
        wr_en   = 2'b01;
        wr_addr = {4'd0, 4'd2};
        wr_data = {32'h0, 32'h7};
        tick();
        rd_chk(4'd2, 32'h7, "pre_clear_reg2");
        clr_req = 1'b1;
        wr_en   = 2'b11;
        wr_addr = {4'd4, 4'd4};
        wr_data = {32'h9, 32'h9};
        tick();
        idle();
        chk("clear_busy", 32'(busy), 32'h1);
        chk("clear_no_conflict", 32'(wr_conflict), 32'h0);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            if (n == 5) begin
                clr_req = 1'b1;
                wr_en   = 2'b01;
                wr_addr = {4'd0, 4'd3};
                wr_data = {32'h0, 32'h55};
            end else begin
                idle();
            end
            n++;
            tick();
        end
        idle();
        chk("clear_sweep_len", 32'(n), 32'd16);
        rd_chk(4'd2, 32'h0, "clear_reg2");
        rd_chk(4'd3, 32'h0, "clear_reg3_write_ignored");
        rd_chk(4'd4, 32'h0, "clear_reg4_dropped");
        rd_chk(4'd5, 32'h0, "clear_reg5");

        // Reset mid-sweep restarts the sweep from index 0
        wr_en   = 2'b01;
        wr_addr = {4'd0, 4'd12};
        wr_data = {32'h0, 32'h77};
        tick();
        rd_chk(4'd12, 32'h77, "pre_restart_reg12");
        clr_req = 1'b1;
        tick();
        idle();
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            rst_n = (n == 8) ? 1'b0 : 1'b1;
            n++;
            tick();
        end
        rst_n = 1'b1;
        chk("restart_sweep_len", 32'(n), 32'd25);
        chk("restart_conflict", 32'(wr_conflict), 32'h0);
        rd_chk(4'd12, 32'h0, "restart_reg12");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter WIDTH, default 32: register word width in bits.
REQ-002 Parameter DEPTH, default 16: number of registers, power of two, >= 2; AW = log2(DEPTH).
REQ-003 Parameter NRD, default 4: read port count.
REQ-004 Parameter NWR, default 2: write port count.
REQ-005 clk  in  1  sole clock; all state changes on rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 rd_addr  in  NRD*AW  read addresses, port i at bits [i*AW +: AW].
REQ-008 rd_zero  in  NRD  per-port force-zero.
REQ-009 const_sel  in  1  substitute const_val on read port 0.
REQ-010 const_val  in  WIDTH  constant operand for port 0.
REQ-011 rd_data  out  NRD*WIDTH  read data, port i at [i*WIDTH +: WIDTH].
REQ-012 wr_en  in  NWR  per-port write enable.
REQ-013 wr_addr  in  NWR*AW  write addresses.
REQ-014 wr_data  in  NWR*WIDTH  write data.
REQ-015 fwd_en  in  1  enable write-to-read bypass.
REQ-016 clr_req  in  1  request soft clear sweep.
REQ-017 busy  out  1  high while clear sweep runs.
REQ-018 wr_conflict  out  1  one-cycle flag: previous cycle had an address collision between enabled write ports.

Function
REQ-019 Reads are combinational; per-port priority: rd_zero -> 0; else (port 0 only) const_sel -> const_val; else busy -> 0; else bypass hit -> bypass data; else array[rd_addr].
REQ-020 Bypass hit: fwd_en=1, busy=0, some wr_en[j]=1 with wr_addr[j]==rd_addr[i]; data = wr_data of highest such j.
REQ-021 With fwd_en=0, a same-cycle write is visible on reads only from the next cycle.
REQ-022 In READY, each enabled write port updates array[wr_addr[j]] at the clock edge; on address collision the highest-index port wins.
REQ-023 wr_conflict is registered: high in cycle n+1 iff cycle n (READY, clr_req=0) had >= 2 enabled write ports to one address; low otherwise.
REQ-024 States: CLEAR, READY. CLEAR: array[cnt] <= 0, cnt increments; when cnt == DEPTH-1 the write occurs, cnt wraps to 0, and state -> READY.
REQ-025 CLEAR lasts exactly DEPTH cycles; busy = (state == CLEAR).
REQ-026 In READY, clr_req=1 -> CLEAR next cycle with cnt=0; writes presented that cycle are dropped; wr_conflict low next cycle.
REQ-027 clr_req during CLEAR is ignored (no restart); wr_en during CLEAR is ignored.
REQ-028 All widths exact; no arithmetic beyond cnt increment modulo DEPTH.

Reset
REQ-029 rst_n=0 at an edge: state <= CLEAR, cnt <= 0, wr_conflict <= 0; held while rst_n=0.
REQ-030 After rst_n rises, sweep runs DEPTH cycles; busy=1 throughout reset and sweep, so rd_data reads 0 except rd_zero/const paths.
REQ-031 Reset asserted mid-sweep or mid-operation restarts sweep at cnt=0; no partial-write effects leak into READY.

Structure
REQ-032 Shared package reg_bank_pkg holds state enum (CLEAR, READY) and default parameter constants.
REQ-033 One sub-module reg_bank_clear_fsm (state, cnt, busy); array, read muxes, bypass, conflict detect in reg_bank.

Verification
REQ-034 Reset 1 cycle, release: busy=1 exactly DEPTH cycles (16), then 0; read all registers -> 0.
REQ-035 READY, wr_en=01, addr 3, data 0xDEADBEEF, rd_addr[1]=3, fwd_en=1 -> rd_data port1=0xDEADBEEF same cycle; fwd_en=0 -> old value 0 same cycle, 0xDEADBEEF next.
REQ-036 wr_en=11, both addr 5, data 0x11/0x22 -> reg5=0x22, wr_conflict=1 next cycle only.
REQ-037 const_sel=1, const_val=0xA5A5A5A5, rd_zero[0]=1 -> port0=0; rd_zero[0]=0 -> 0xA5A5A5A5 even while busy.
REQ-038 Write 0x7 to reg 2, then clr_req with concurrent write 0x9 to reg 4 -> busy 16 cycles, reg2=0, reg4=0; clr_req at sweep cycle 5 -> no extension.
REQ-039 rst_n low at sweep cycle 8 for 1 cycle -> busy stays high, sweep restarts, READY 16 cycles after release.
